// File: rtl/gen_reg_file.sv
// Bank of NREG general-purpose registers sharing one operation code, with
// per-register active-low select, two combinational read ports and sticky boundary flags.
module gen_reg_file #(
   parameter int WIDTH = 8,
   parameter int NREG  = 4,
   parameter int SAT   = 0,
   localparam int SW   = $clog2(NREG)
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [WIDTH-1:0] I,
   input  logic [2:0]       FunSel,
   input  logic [NREG-1:0]  RegSel,
   input  logic [SW-1:0]    OutASel,
   input  logic [SW-1:0]    OutBSel,
   output logic [WIDTH-1:0] OutA,
   output logic [WIDTH-1:0] OutB,
   output logic [NREG-1:0]  Flag
);

   localparam logic [2:0] OpDec = 3'b000;
   localparam logic [2:0] OpInc = 3'b001;
   localparam logic [2:0] OpLoad = 3'b010;
   localparam logic [2:0] OpClr = 3'b011;
   localparam logic [2:0] OpShl = 3'b100;
   localparam logic [2:0] OpShr = 3'b101;
   localparam logic [2:0] OpRol = 3'b110;

   localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};

   logic [WIDTH-1:0] regs [NREG];
   logic [WIDTH:0]   stepRes [NREG];

   // Inc/dec at the boundary: returns {hitLimit, newValue}, wrapping or saturating by SAT.
   function automatic logic [WIDTH:0] incDecStep(input logic [WIDTH-1:0] v, input logic up);
      logic [WIDTH-1:0] lim;
      lim = up ? MaxVal : '0;
      if (v == lim)
         return {1'b1, (SAT != 0) ? lim : ~lim};
      return {1'b0, up ? v + WIDTH'(1) : v - WIDTH'(1)};
   endfunction

   function automatic logic [WIDTH:0] nextVal(input logic [2:0] op,
                                             input logic [WIDTH-1:0] v,
                                             input logic [WIDTH-1:0] d);
      case (op)
         OpDec:   return incDecStep(v, 1'b0);
         OpInc:   return incDecStep(v, 1'b1);
         OpLoad:  return {1'b0, d};
         OpClr:   return '0;
         OpShl:   return {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
         OpShr:   return {v[0], 1'b0, v[WIDTH-1:1]};
         OpRol:   return {1'b0, v[WIDTH-2:0], v[WIDTH-1]};
         default: return {1'b0, v};
      endcase
   endfunction

   always_comb begin
      for (int k = 0; k < NREG; k++)
         stepRes[k] = nextVal(FunSel, regs[k], I);
   end

   // Flag is sticky: only a clear of that register (or reset) drops it.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int k = 0; k < NREG; k++)
            regs[k] <= '0;
         Flag <= '0;
      end else begin
         for (int k = 0; k < NREG; k++) begin
            if (!RegSel[k]) begin
               regs[k] <= stepRes[k][WIDTH-1:0];
               if (FunSel == OpClr)
                  Flag[k] <= 1'b0;
               else if (stepRes[k][WIDTH])
                  Flag[k] <= 1'b1;
            end
         end
      end
   end

   // Out-of-range indices fall through to zero.
   always_comb begin
      OutA = '0;
      OutB = '0;
      for (int k = 0; k < NREG; k++) begin
         if (OutASel == SW'(k)) OutA = regs[k];
         if (OutBSel == SW'(k)) OutB = regs[k];
      end
   end

endmodule

// File: tb/tb_gen_reg_file.sv
// Scoreboard bench: wrapping 8-bit bank, saturating 3-register bank and a 16-bit/8-register bank.
module tb_gen_reg_file;

   typedef struct {
      int          dut;
      string       name;
      logic [15:0] a;
      logic [15:0] b;
      logic [7:0]  f;
   } exp_t;

   exp_t expQ[$];
   int   numChecks = 0;
   int   numFails  = 0;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;

   logic [7:0] i8 = '0;
   logic [2:0] funSel8 = 3'b111;
   logic [3:0] regSel8 = '1;
   logic [1:0] aSel8 = '0, bSel8 = '0;
   logic [7:0] outAw, outBw, outAs, outBs;
   logic [3:0] flagW;
   logic [2:0] flagS;

   logic [15:0] i16 = '0;
   logic [2:0]  funSel16 = 3'b111;
   logic [7:0]  regSel16 = '1;
   logic [2:0]  aSel16 = '0, bSel16 = '0;
   logic [15:0] outA16, outB16;
   logic [7:0]  flag16;

   always #5 Clk = ~Clk;

   gen_reg_file #(.WIDTH(8), .NREG(4), .SAT(0)) dutWrap (
      .Clk(Clk), .Rst(Rst), .I(i8), .FunSel(funSel8), .RegSel(regSel8),
      .OutASel(aSel8), .OutBSel(bSel8), .OutA(outAw), .OutB(outBw), .Flag(flagW));

   gen_reg_file #(.WIDTH(8), .NREG(3), .SAT(1)) dutSat (
      .Clk(Clk), .Rst(Rst), .I(i8), .FunSel(funSel8), .RegSel(regSel8[2:0]),
      .OutASel(aSel8), .OutBSel(bSel8), .OutA(outAs), .OutB(outBs), .Flag(flagS));

   gen_reg_file #(.WIDTH(16), .NREG(8), .SAT(0)) dutWide (
      .Clk(Clk), .Rst(Rst), .I(i16), .FunSel(funSel16), .RegSel(regSel16),
      .OutASel(aSel16), .OutBSel(bSel16), .OutA(outA16), .OutB(outB16), .Flag(flag16));

   task automatic compare(input string name, input string what, input int dut,
                          input logic [15:0] got, input logic [15:0] want);
      numChecks++;
      if (got !== want) begin
         numFails++;
         $display("FAIL %s dut%0d %s: got %h, expected %h", name, dut, what, got, want);
      end
   endtask

   // Monitor: the read ports are combinational, so every pending expectation is due at the next negedge.
   always @(negedge Clk) begin
      exp_t e;
      logic [15:0] gotA, gotB;
      logic [7:0]  gotF;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         case (e.dut)
            0:       begin gotA = {8'h0, outAw}; gotB = {8'h0, outBw}; gotF = {4'h0, flagW}; end
            1:       begin gotA = {8'h0, outAs}; gotB = {8'h0, outBs}; gotF = {5'h0, flagS}; end
            default: begin gotA = outA16; gotB = outB16; gotF = flag16; end
         endcase
         compare(e.name, "OutA", e.dut, gotA, e.a);
         compare(e.name, "OutB", e.dut, gotB, e.b);
         compare(e.name, "Flag", e.dut, {8'h0, gotF}, {8'h0, e.f});
      end
   end

   task automatic op8(input logic [2:0] fs, input logic [3:0] rs, input logic [7:0] d, input int n);
      funSel8 = fs; regSel8 = rs; i8 = d;
      repeat (n) @(posedge Clk);
      #1;
      funSel8 = 3'b111; regSel8 = '1;
   endtask

   task automatic op16(input logic [2:0] fs, input logic [7:0] rs, input logic [15:0] d, input int n);
      funSel16 = fs; regSel16 = rs; i16 = d;
      repeat (n) @(posedge Clk);
      #1;
      funSel16 = 3'b111; regSel16 = '1;
   endtask

   task automatic chk8(input string name, input logic [1:0] a, input logic [1:0] b,
                       input logic [7:0] aW, input logic [7:0] bW, input logic [3:0] fW,
                       input logic [7:0] aS, input logic [7:0] bS, input logic [2:0] fS);
      aSel8 = a; bSel8 = b;
      expQ.push_back('{0, name, {8'h0, aW}, {8'h0, bW}, {4'h0, fW}});
      expQ.push_back('{1, name, {8'h0, aS}, {8'h0, bS}, {5'h0, fS}});
      @(negedge Clk);
      #1;
   endtask

   task automatic chk16(input string name, input logic [2:0] a, input logic [2:0] b,
                        input logic [15:0] ea, input logic [15:0] eb, input logic [7:0] ef);
      aSel16 = a; bSel16 = b;
      expQ.push_back('{2, name, ea, eb, ef});
      @(negedge Clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach its end, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Rst = 1'b0;

      chk8("reset", 2'd0, 2'd1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 3'h0);
      op8(3'b010, 4'b1110, 8'hAA, 1);
      chk8("load", 2'd0, 2'd1, 8'hAA, 8'h00, 4'h0, 8'hAA, 8'h00, 3'h0);

      op8(3'b010, 4'b1101, 8'hFF, 1);
      op8(3'b001, 4'b1101, 8'h00, 1);
      chk8("inc limit", 2'd1, 2'd0, 8'h00, 8'hAA, 4'h2, 8'hFF, 8'hAA, 3'h2);
      op8(3'b001, 4'b1101, 8'h00, 1);
      chk8("inc after limit", 2'd1, 2'd0, 8'h01, 8'hAA, 4'h2, 8'hFF, 8'hAA, 3'h2);

      op8(3'b000, 4'b1011, 8'h00, 3);
      chk8("dec limit", 2'd2, 2'd1, 8'hFD, 8'h01, 4'h6, 8'h00, 8'hFF, 3'h6);
      op8(3'b011, 4'b1011, 8'h00, 1);
      chk8("clear", 2'd2, 2'd2, 8'h00, 8'h00, 4'h2, 8'h00, 8'h00, 3'h2);

      op8(3'b010, 4'b0111, 8'h81, 1);
      op8(3'b100, 4'b0111, 8'h00, 1);
      chk8("shl", 2'd3, 2'd0, 8'h02, 8'hAA, 4'hA, 8'h00, 8'hAA, 3'h2);
      op8(3'b011, 4'b0111, 8'h00, 1);
      op8(3'b010, 4'b0111, 8'h81, 1);
      op8(3'b110, 4'b0111, 8'h00, 1);
      chk8("rol", 2'd3, 2'd1, 8'h03, 8'h01, 4'h2, 8'h00, 8'hFF, 3'h2);
      op8(3'b101, 4'b0111, 8'h00, 1);
      chk8("shr", 2'd3, 2'd3, 8'h01, 8'h01, 4'hA, 8'h00, 8'h00, 3'h2);
      op8(3'b010, 4'b1011, 8'h40, 1);
      op8(3'b100, 4'b1011, 8'h00, 1);
      chk8("shl quiet", 2'd2, 2'd0, 8'h80, 8'hAA, 4'hA, 8'h80, 8'hAA, 3'h2);

      op8(3'b010, 4'b0000, 8'h5C, 1);
      chk8("multi lo", 2'd0, 2'd1, 8'h5C, 8'h5C, 4'hA, 8'h5C, 8'h5C, 3'h2);
      chk8("multi hi", 2'd2, 2'd3, 8'h5C, 8'h5C, 4'hA, 8'h5C, 8'h00, 3'h2);
      op8(3'b111, 4'b0000, 8'h00, 3);
      chk8("hold", 2'd1, 2'd3, 8'h5C, 8'h5C, 4'hA, 8'h5C, 8'h00, 3'h2);
      op8(3'b011, 4'b1111, 8'h00, 1);
      chk8("unselected", 2'd0, 2'd2, 8'h5C, 8'h5C, 4'hA, 8'h5C, 8'h5C, 3'h2);

      funSel8 = 3'b001; regSel8 = 4'b0000;
      repeat (2) @(posedge Clk);
      #2 Rst = 1'b1;
      chk8("async reset", 2'd0, 2'd1, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00, 3'h0);
      funSel8 = 3'b111; regSel8 = '1;
      Rst = 1'b0;
      op8(3'b001, 4'b0000, 8'h00, 1);
      chk8("resume", 2'd3, 2'd2, 8'h01, 8'h01, 4'h0, 8'h00, 8'h01, 3'h0);

      Rst = 1'b1;
      @(posedge Clk);
      #1 Rst = 1'b0;
      chk16("wide reset", 3'd7, 3'd0, 16'h0000, 16'h0000, 8'h00);
      op16(3'b010, 8'hFE, 16'hAAAA, 1);
      chk16("wide load", 3'd0, 3'd1, 16'hAAAA, 16'h0000, 8'h00);
      op16(3'b010, 8'h7F, 16'hFFFF, 1);
      op16(3'b001, 8'h7F, 16'h0000, 1);
      chk16("wide inc limit", 3'd7, 3'd0, 16'h0000, 16'hAAAA, 8'h80);
      op16(3'b001, 8'h7F, 16'h0000, 1);
      chk16("wide inc after", 3'd7, 3'd7, 16'h0001, 16'h0001, 8'h80);
      op16(3'b010, 8'hBF, 16'h1234, 1);
      chk16("wide r6", 3'd6, 3'd7, 16'h1234, 16'h0001, 8'h80);

      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
      $finish;
   end

endmodule

// File: doc/gen_reg_file.md
GEN_REG_FILE -- requirements
Module: gen_reg_file

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bit width of each register.
REQ-002 SHALL have parameter NREG, default 4, meaning the register count (legal range 2..16).
REQ-003 SHALL have parameter SAT, default 0, meaning the inc/dec boundary mode (0 wraps, 1 saturates).
REQ-004 SHALL have port Clk  input  1  system clock; all state updates on its rising edge.
REQ-005 SHALL have port Rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port I  input  WIDTH  load data.
REQ-007 SHALL have port FunSel  input  3  operation code applied to every selected register.
REQ-008 SHALL have port RegSel  input  NREG  per-register select, active-low (bit k = 0 selects register k).
REQ-009 SHALL have port OutASel  input  SW  read port A index, where SW = $clog2(NREG).
REQ-010 SHALL have port OutBSel  input  SW  read port B index.
REQ-011 SHALL have port OutA  output  WIDTH  contents of register OutASel.
REQ-012 SHALL have port OutB  output  WIDTH  contents of register OutBSel.
REQ-013 SHALL have port Flag  output  NREG  sticky boundary flag, one bit per register.

Function
REQ-014 SHALL decode FunSel as follows: 000 decrement, 001 increment, 010 load I, 011 clear to 0, 100 logical shift left with 0 in, 101 logical shift right with 0 in, 110 rotate left, 111 hold.
REQ-015 SHALL apply the FunSel operation on the rising Clk edge to every register whose RegSel bit is 0, all in the same cycle.
REQ-016 SHALL leave registers whose RegSel bit is 1 unchanged, together with their Flag bits.
REQ-017 SHALL, when SAT=0, wrap increment of 2^WIDTH-1 to 0 and decrement of 0 to 2^WIDTH-1, and set that register's Flag bit on the same edge.
REQ-018 SHALL, when SAT=1, hold increment at 2^WIDTH-1 and decrement at 0, and set that register's Flag bit when an increment or decrement is attempted at the limit.
REQ-019 SHALL set a register's Flag bit on a shift-left whose discarded MSB is 1, or on a shift-right whose discarded LSB is 1.
REQ-020 SHALL leave Flag unchanged on rotate, load and hold, and leave it unchanged on inc/dec/shift operations that do not trigger it.
REQ-021 SHALL clear a register's Flag bit only on a clear (011) of that register or on Rst.
REQ-022 SHALL drive OutA/OutB combinationally from current register state, so a value written at edge n is visible after edge n with 0-cycle read latency.
REQ-023 SHALL return 0 on OutA/OutB when the select index is >= NREG.
REQ-024 SHALL allow both read ports to select the same register.

Reset
REQ-025 SHALL, while Rst=1, force all registers to 0 and Flag to 0 immediately, independent of Clk.
REQ-026 SHALL drive OutA=0 and OutB=0 for any in-range select while Rst=1.
REQ-027 SHALL give Rst priority over any FunSel/RegSel activity, including assertion mid-cycle.
REQ-028 SHALL resume normal operation on the first rising Clk edge after Rst deasserts.

Verification
REQ-029 SHALL cover reset then load (defaults): Rst pulse; RegSel=1110, FunSel=010, I=AA, 1 edge -> OutASel=0 gives AA, OutBSel=1 gives 00, Flag=0000.
REQ-030 SHALL cover wrap (SAT=0): R1 loaded FF; RegSel=1101, FunSel=001, 1 edge -> R1=00, Flag[1]=1; 1 more edge -> R1=01, Flag[1] still 1.
REQ-031 SHALL cover saturation (SAT=1): R2=00; FunSel=000 for 3 edges -> R2 stays 00, Flag[2]=1; FunSel=011, 1 edge -> Flag[2]=0.
REQ-032 SHALL cover shift and rotate: R3=81; FunSel=100 -> 02 with Flag[3]=1; reload 81, FunSel=110 -> 03 with Flag[3] unchanged; FunSel=101 on 03 -> 01 with Flag set.
REQ-033 SHALL cover multi-select and hold: RegSel=0000, FunSel=010, I=5C -> all four registers read 5C; FunSel=111, 3 edges -> unchanged; RegSel=1111 with FunSel=011 -> unchanged.
REQ-034 SHALL cover asynchronous reset mid-operation and parametrisation: Rst asserted between edges during an increment burst -> outputs 0 before the next edge; repeat REQ-029/030 with WIDTH=16, NREG=8 (FFFF wraps to 0000; OutASel=7 reads R7).
